// File: rtl/ram_loader.sv
// Boot-time program loader: packs serial bytes into 32-bit words and writes
// them to data RAM while stalling the CPU; otherwise passes CPU accesses through.
module ram_loader #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic [31:0]      load_base_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic             cpu_ce_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [3:0]       cpu_sel_i,
  input  logic [31:0]      cpu_data_i,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [3:0]       ram_sel_o,
  output logic [31:0]      ram_data_o,
  output logic             stall_o,
  output logic             load_busy_o,
  output logic             load_done_o,
  output logic [LEN_W-1:0] word_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       idx;
  logic [31:0]      word;
  logic [31:0]      base;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [31:0]      offs;

  assign cnt_inc    = cnt + LEN_W'(1);
  assign offs       = 32'(cnt) << 2;
  assign word_cnt_o = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      word  <= '0;
      base  <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (load_start_i) begin
            base <= {load_base_i[31:2], 2'b00};
            len  <= load_len_i;
            cnt  <= '0;
            idx  <= 2'd0;
          end
        end
        RECV: begin
          // big-endian: earlier bytes shift toward the MSB
          if (rx_valid_i) begin
            word <= {word[23:0], rx_data_i};
            idx  <= idx + 2'd1;
          end
        end
        WRITE: begin
          cnt <= cnt_inc;
          idx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    rx_ready_o  = 1'b0;
    stall_o     = 1'b1;
    load_busy_o = 1'b1;
    load_done_o = 1'b0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_sel_o   = '0;
    ram_data_o  = '0;
    unique case (state)
      IDLE: begin
        stall_o     = 1'b0;
        load_busy_o = 1'b0;
        ram_ce_o    = cpu_ce_i;
        ram_we_o    = cpu_we_i;
        ram_addr_o  = cpu_addr_i;
        ram_sel_o   = cpu_sel_i;
        ram_data_o  = cpu_data_i;
        if (load_start_i)
          state_nx = (load_len_i != '0) ? RECV : DONE;
      end
      RECV: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && idx == 2'd3)
          state_nx = WRITE;
      end
      WRITE: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_sel_o  = 4'b1111;
        ram_addr_o = base + offs;
        ram_data_o = word;
        state_nx   = (cnt_inc == len) ? DONE : RECV;
      end
      DONE: begin
        load_done_o = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: expected RAM writes are queued when a load is
// started and checked by a monitor as the loader writes them.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start_i;
  logic [31:0] load_base_i;
  logic [15:0] load_len_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic        stall_o;
  logic        load_busy_o;
  logic        load_done_o;
  logic [15:0] word_cnt_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  ram_loader #(.LEN_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .load_base_i  (load_base_i),
    .load_len_i   (load_len_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .cpu_ce_i     (cpu_ce_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_sel_i    (cpu_sel_i),
    .cpu_data_i   (cpu_data_i),
    .ram_ce_o     (ram_ce_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_sel_o    (ram_sel_o),
    .ram_data_o   (ram_data_o),
    .stall_o      (stall_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .word_cnt_o   (word_cnt_o)
  );

  // loader-issued writes are those seen while the CPU is stalled
  always @(negedge clk) begin
    if (rst && stall_o && ram_we_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%h data=%h", ram_addr_o, ram_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr_o !== mon_e.addr || ram_data_o !== mon_e.data ||
            ram_sel_o !== 4'hf || ram_ce_o !== 1'b1) begin
          n_err++;
          $display("FAIL ram_write got addr=%h data=%h sel=%b ce=%b want addr=%h data=%h sel=1111 ce=1",
                   ram_addr_o, ram_data_o, ram_sel_o, ram_ce_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic start_load(input logic [31:0] b, input logic [15:0] l);
    load_base_i  = b;
    load_len_i   = l;
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n,
                            input bit gap, input int xs);
    for (int k = 0; k < n; k++) begin
      int t;
      if (gap) begin
        rx_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      rx_data_i    = bytes[63-8*k -: 8];
      rx_valid_i   = 1'b1;
      load_start_i = (k == xs);
      t = 0;
      @(negedge clk);
      n_cmp++;
      if (stall_o !== 1'b1) begin
        n_err++;
        $display("FAIL stall_during_load got=%b want=1", stall_o);
      end
      while (!rx_ready_o && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rx_ready_o) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_ready_timeout got=0 want=1");
      end
      @(posedge clk); #1;
      load_start_i = 1'b0;
      rx_valid_i   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_start_i = 0; load_base_i = 0; load_len_i = 0;
    rx_data_i = 0; rx_valid_i = 0;
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h44;
    cpu_sel_i = 4'b0011; cpu_data_i = 32'h12345678;
    #12;
    n_cmp++;
    if (load_busy_o !== 0 || load_done_o !== 0 || rx_ready_o !== 0 ||
        stall_o !== 0 || word_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b rdy=%b stall=%b cnt=%0d want 0 0 0 0 0",
               load_busy_o, load_done_o, rx_ready_o, stall_o, word_cnt_o);
    end
    n_cmp++;
    if (ram_we_o !== 1 || ram_ce_o !== 1 || ram_addr_o !== 32'h44 ||
        ram_sel_o !== 4'b0011 || ram_data_o !== 32'h12345678) begin
      n_err++;
      $display("FAIL reset_passthru got addr=%h data=%h want addr=00000044 data=12345678",
               ram_addr_o, ram_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0; cpu_data_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h20;
    cpu_sel_i = 4'b0100; cpu_data_i = 32'hAABBCCDD;
    #1;
    n_cmp++;
    if (ram_ce_o !== 1 || ram_we_o !== 1 || ram_addr_o !== 32'h20 ||
        ram_sel_o !== 4'b0100 || ram_data_o !== 32'hAABBCCDD || stall_o !== 0) begin
      n_err++;
      $display("FAIL passthru_write got ce=%b we=%b addr=%h sel=%b data=%h stall=%b want 1 1 00000020 0100 aabbccdd 0",
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, stall_o);
    end
    cpu_we_i = 0; cpu_addr_i = 32'h24; cpu_sel_i = 4'b1001;
    #1;
    n_cmp++;
    if (ram_we_o !== 0 || ram_addr_o !== 32'h24 || ram_sel_o !== 4'b1001 ||
        rx_ready_o !== 0) begin
      n_err++;
      $display("FAIL passthru_read got we=%b addr=%h sel=%b rdy=%b want 0 00000024 1001 0",
               ram_we_o, ram_addr_o, ram_sel_o, rx_ready_o);
    end
    cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_sel_i = 0; cpu_data_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    exp_q.push_back('{addr: 32'h100, data: 32'h11223344});
    exp_q.push_back('{addr: 32'h104, data: 32'h55667788});
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h80; cpu_data_i = 32'hFFFF0000;
    start_load(32'h100, 16'd2);
    send_bytes(64'h1122334455667788, 8, 1'b0, -1);
    @(negedge clk);
    n_cmp++;
    if (ram_we_o !== 1 || ram_addr_o !== 32'h104 || load_done_o !== 0) begin
      n_err++;
      $display("FAIL basic_last_write got we=%b addr=%h done=%b want 1 00000104 0",
               ram_we_o, ram_addr_o, load_done_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 1 || word_cnt_o !== 16'd2 || ram_we_o !== 0) begin
      n_err++;
      $display("FAIL basic_done got done=%b cnt=%0d we=%b want 1 2 0",
               load_done_o, word_cnt_o, ram_we_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 0 || load_busy_o !== 0 || word_cnt_o !== 16'd2) begin
      n_err++;
      $display("FAIL basic_idle got done=%b busy=%b cnt=%0d want 0 0 2",
               load_done_o, load_busy_o, word_cnt_o);
    end
    cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_rx_gaps();
    exp_q.push_back('{addr: 32'h100, data: 32'h11223344});
    exp_q.push_back('{addr: 32'h104, data: 32'h55667788});
    start_load(32'h100, 16'd2);
    send_bytes(64'h1122334455667788, 8, 1'b1, -1);
    @(negedge clk);
    n_cmp++;
    if (ram_we_o !== 1 || ram_data_o !== 32'h55667788) begin
      n_err++;
      $display("FAIL gaps_last_write got we=%b data=%h want 1 55667788", ram_we_o, ram_data_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 1 || word_cnt_o !== 16'd2 || stall_o !== 1) begin
      n_err++;
      $display("FAIL gaps_done got done=%b cnt=%0d stall=%b want 1 2 1",
               load_done_o, word_cnt_o, stall_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    start_load(32'h500, 16'd0);
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 1 || rx_ready_o !== 0 || load_busy_o !== 1 ||
        ram_we_o !== 0 || word_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL len0_done got done=%b rdy=%b busy=%b we=%b cnt=%0d want 1 0 1 0 0",
               load_done_o, rx_ready_o, load_busy_o, ram_we_o, word_cnt_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 0 || load_busy_o !== 0 || rx_ready_o !== 0) begin
      n_err++;
      $display("FAIL len0_idle got done=%b busy=%b rdy=%b want 0 0 0",
               load_done_o, load_busy_o, rx_ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    start_load(32'h200, 16'd1);
    send_bytes(64'hDEAD000000000000, 2, 1'b0, -1);
    rx_data_i  = 8'hBE;
    rx_valid_i = 1'b1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (load_busy_o !== 0 || word_cnt_o !== 16'd0 || rx_ready_o !== 0 ||
        stall_o !== 0 || ram_we_o !== 0) begin
      n_err++;
      $display("FAIL midreset got busy=%b cnt=%0d rdy=%b stall=%b we=%b want 0 0 0 0 0",
               load_busy_o, word_cnt_o, rx_ready_o, stall_o, ram_we_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rx_valid_i = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{addr: 32'h300, data: 32'hA1B2C3D4});
    start_load(32'h303, 16'd1);
    send_bytes(64'hA1B2C3D400000000, 4, 1'b0, -1);
    @(negedge clk);
    n_cmp++;
    if (ram_we_o !== 1 || ram_addr_o !== 32'h300) begin
      n_err++;
      $display("FAIL fresh_write got we=%b addr=%h want 1 00000300", ram_we_o, ram_addr_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 1 || word_cnt_o !== 16'd1) begin
      n_err++;
      $display("FAIL fresh_done got done=%b cnt=%0d want 1 1", load_done_o, word_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_extra_start();
    exp_q.push_back('{addr: 32'hFFFFFFFC, data: 32'h01020304});
    exp_q.push_back('{addr: 32'h00000000, data: 32'h05060708});
    start_load(32'hFFFFFFFC, 16'd2);
    load_base_i = 32'h400;
    load_len_i  = 16'd5;
    send_bytes(64'h0102030405060708, 8, 1'b0, 2);
    @(negedge clk);
    n_cmp++;
    if (ram_we_o !== 1 || ram_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_write got we=%b addr=%h want 1 00000000", ram_we_o, ram_addr_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done_o !== 1 || word_cnt_o !== 16'd2) begin
      n_err++;
      $display("FAIL wrap_done got done=%b cnt=%0d want 1 2", load_done_o, word_cnt_o);
    end
    @(negedge clk);
    n_cmp++;
    if (load_busy_o !== 0 || load_done_o !== 0) begin
      n_err++;
      $display("FAIL wrap_idle got busy=%b done=%b want 0 0", load_busy_o, load_done_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic_load();
    test_rx_gaps();
    test_len_zero();
    test_reset_mid_load();
    test_wrap_extra_start();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_writes got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter LEN_W, default 16, width of the word-count input and the progress counter.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 load_start_i  in  1  one-cycle request to begin a program load.
REQ-005 load_base_i  in  32  byte address of first word; bits [1:0] ignored (treated as 0).
REQ-006 load_len_i  in  LEN_W  number of 32-bit words to load.
REQ-007 rx_data_i  in  8  incoming program byte.
REQ-008 rx_valid_i  in  1  rx_data_i valid.
REQ-009 rx_ready_o  out  1  loader accepts byte this cycle.
REQ-010 cpu_ce_i, cpu_we_i  in  1 each  CPU memory-stage chip enable and write enable.
REQ-011 cpu_addr_i  in  32, cpu_sel_i  in  4, cpu_data_i  in  32  CPU address, byte select and write data.
REQ-012 ram_ce_o, ram_we_o  out  1 each  data RAM chip enable and write enable.
REQ-013 ram_addr_o  out  32, ram_sel_o  out  4, ram_data_o  out  32  data RAM address, byte select and write data.
REQ-014 stall_o  out  1  pipeline stall request to CPU while loading.
REQ-015 load_busy_o  out  1  high in any state other than IDLE.
REQ-016 load_done_o  out  1  one-cycle completion pulse.
REQ-017 word_cnt_o  out  LEN_W  words written so far in the current load.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-019 IDLE -> RECV on load_start_i=1 with load_len_i!=0; IDLE -> DONE on load_start_i=1 with load_len_i==0; base and length captured on that edge.
REQ-020 load_start_i outside IDLE SHALL be ignored.
REQ-021 rx_ready_o SHALL be 1 only in RECV; a byte transfers on a cycle with rx_valid_i=1 and rx_ready_o=1.
REQ-022 Bytes SHALL pack big-endian: 1st byte -> word[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-023 After the 4th byte transfer, the FSM SHALL enter WRITE for exactly one cycle.
REQ-024 In WRITE: ram_ce_o=1, ram_we_o=1, ram_sel_o=4'b1111, ram_addr_o=base+4*word_cnt (mod 2^32), ram_data_o=assembled word.
REQ-025 Leaving WRITE, word_cnt increments; then -> DONE if new count equals captured length, else -> RECV with byte index 0.
REQ-026 DONE SHALL last one cycle with load_done_o=1, then -> IDLE; word_cnt_o holds its final value until the next accepted start.
REQ-027 In IDLE, ram_* outputs SHALL equal the corresponding cpu_* inputs combinationally (zero-latency pass-through); stall_o=0.
REQ-028 In RECV, WRITE and DONE, stall_o=1, cpu_* inputs SHALL be ignored, and outside WRITE ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0.
REQ-029 rx_valid_i gaps of any length in RECV SHALL preserve the partial word and byte index.
REQ-030 word_cnt wraps modulo 2^LEN_W; lengths up to 2^LEN_W-1 are supported.

Reset
REQ-031 On rst=0, immediately: state IDLE, byte index 0, word_cnt_o=0, captured base/length 0, load_done_o=0, rx_ready_o=0, stall_o=0, ram_* follow cpu_*.
REQ-032 Reset mid-load SHALL abandon the load; a partial word SHALL NOT be written.

Verification
REQ-033 base=0x100, len=2, bytes 11 22 33 44 55 66 77 88, rx_valid_i always 1 -> writes 0x11223344 @0x100 and 0x55667788 @0x104, sel=1111, load_done_o pulse one cycle after 2nd WRITE, word_cnt_o=2.
REQ-034 Same load with rx_valid_i toggling 1/0 each cycle -> identical writes; no WRITE before 4th accepted byte; stall_o=1 throughout.
REQ-035 load_start_i with load_len_i=0 -> DONE next cycle, load_done_o=1 for one cycle, no RAM write, rx_ready_o stays 0.
REQ-036 Idle, cpu_ce_i=1, cpu_we_i=1, cpu_addr_i=0x20, cpu_sel_i=0100, cpu_data_i=0xAABBCCDD -> ram_* equal same values in same cycle; stall_o=0.
REQ-037 rst asserted after 2 of 4 bytes of first word -> no RAM write, state IDLE, word_cnt_o=0; a subsequent load starts fresh at byte index 0.
REQ-038 base=0xFFFFFFFC, len=2, with extra load_start_i during load -> writes at 0xFFFFFFFC then 0x00000000; extra start ignored.
